// File: rtl/cl_mem_sequencer_pkg.sv
// Shared types and constants for the load/store sequencer.
package cl_mem_sequencer_pkg;

    localparam int kAddrWidth   = 32;
    localparam int kDataWidth   = 32;
    localparam int kRfAddrWidth = 5;
    localparam int kLanes       = kDataWidth / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_DONE,
        ST_ERROR
    } mem_seq_state_e;

    typedef logic [1:0] err_code_t;

    localparam err_code_t kErrNone     = 2'd0;
    localparam err_code_t kErrMisalign = 2'd1;
    localparam err_code_t kErrTimeout  = 2'd2;

    // One captured pipeline request, held for the whole transaction.
    typedef struct packed {
        logic                    is_store;
        logic                    is_byte;
        logic [kAddrWidth-1:0]   addr;
        logic [kDataWidth-1:0]   data;
        logic [kRfAddrWidth-1:0] rd;
    } mem_req_s;

    // Word accesses must be 4-byte aligned; byte accesses never fault.
    function automatic logic is_misaligned(input logic is_byte, input logic [1:0] lane);
        return !is_byte && (lane != 2'b00);
    endfunction

endpackage

// File: rtl/cl_mem_sequencer_if.sv
// Data-memory port: request handshake (valid/yumi) plus load response.
interface cl_mem_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    dmem_v_o;
    logic                    dmem_w_o;
    logic [ADDR_WIDTH-1:0]   dmem_addr_o;
    logic [DATA_WIDTH-1:0]   dmem_wdata_o;
    logic [DATA_WIDTH/8-1:0] dmem_mask_o;
    logic                    dmem_yumi_i;
    logic                    dmem_rsp_v_i;
    logic [DATA_WIDTH-1:0]   dmem_rdata_i;

    // Sequencer side.
    modport master (
        output dmem_v_o, dmem_w_o, dmem_addr_o, dmem_wdata_o, dmem_mask_o,
        input  dmem_yumi_i, dmem_rsp_v_i, dmem_rdata_i
    );

    // Memory side.
    modport slave (
        input  dmem_v_o, dmem_w_o, dmem_addr_o, dmem_wdata_o, dmem_mask_o,
        output dmem_yumi_i, dmem_rsp_v_i, dmem_rdata_i
    );
endinterface

// File: rtl/cl_mem_lane_align.sv
// Byte-lane steering: store mask/data replication and load byte extraction.
module cl_mem_lane_align
    import cl_mem_sequencer_pkg::*;
(
    input  logic        is_byte_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    // Word ops pass straight through; byte ops pick or replicate one lane.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mask_o      = 4'hF;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        if (is_byte_i) begin
            mask_o      = 4'b0001 << lane_i;
            wdata_o     = {kLanes{store_data_i[7:0]}};
            load_data_o = {24'b0, rdata_i[{lane_i, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/cl_mem_sequencer.sv
// One-at-a-time load/store sequencer between execute stage and dmem port.
module cl_mem_sequencer
    import cl_mem_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH     = kAddrWidth,
    parameter int DATA_WIDTH     = kDataWidth,
    parameter int RF_ADDR_WIDTH  = kRfAddrWidth,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     is_store_i,
    input  logic                     is_byte_i,
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    input  logic [DATA_WIDTH-1:0]    store_data_i,
    input  logic [RF_ADDR_WIDTH-1:0] rd_addr_i,
    cl_mem_sequencer_if.master       dmem,
    output logic                     wb_v_o,
    output logic [RF_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    output logic                     stall_o,
    output logic                     err_o,
    output logic [1:0]               err_code_o
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_seq_state_e        state_q, state_d;
    mem_req_s              req_q, req_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    err_code_t             err_code_q, err_code_d;

    logic [3:0]            lane_mask;
    logic [31:0]           lane_wdata;
    logic [31:0]           lane_load;

    // Lane logic always works from the captured request, never the live inputs.
    cl_mem_lane_align u_lane_align (
        .is_byte_i    (req_q.is_byte),
        .lane_i       (req_q.addr[1:0]),
        .store_data_i (req_q.data),
        .rdata_i      (dmem.dmem_rdata_i),
        .mask_o       (lane_mask),
        .wdata_o      (lane_wdata),
        .load_data_o  (lane_load)
    );

    // State, captured request, timeout counter and load result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            load_data_q <= '0;
            err_code_q  <= kErrNone;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            err_code_q  <= err_code_d;
        end
    end

    // Next-state logic: capture in IDLE, handshake in REQ, bounded wait for the load.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        err_code_d  = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    req_d.is_store = is_store_i;
                    req_d.is_byte  = is_byte_i;
                    req_d.addr     = addr_i;
                    req_d.data     = store_data_i;
                    req_d.rd       = rd_addr_i;
                    if (is_misaligned(is_byte_i, addr_i[1:0])) begin
                        state_d    = ST_ERROR;
                        err_code_d = kErrMisalign;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                // Memory may back-pressure indefinitely here; only the response wait is timed.
                if (dmem.dmem_yumi_i) begin
                    cnt_d   = '0;
                    state_d = req_q.is_store ? ST_IDLE : ST_WAIT_RSP;
                end
            end

            ST_WAIT_RSP: begin
                // A response on the final counted cycle still completes the load.
                if (dmem.dmem_rsp_v_i) begin
                    load_data_d = lane_load;
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    err_code_d = kErrTimeout;
                    state_d    = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            ST_ERROR: begin
                err_code_d = kErrNone;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs; bus and writeback fields read zero outside their owning state.
    always_comb begin
        req_ready_o       = (state_q == ST_IDLE);
        stall_o           = (state_q != ST_IDLE);
        dmem.dmem_v_o     = 1'b0;
        dmem.dmem_w_o     = 1'b0;
        dmem.dmem_addr_o  = '0;
        dmem.dmem_wdata_o = '0;
        dmem.dmem_mask_o  = '0;
        wb_v_o            = 1'b0;
        wb_addr_o         = '0;
        wb_data_o         = '0;
        err_o             = 1'b0;
        err_code_o        = kErrNone;

        case (state_q)
            ST_REQ: begin
                dmem.dmem_v_o    = 1'b1;
                dmem.dmem_w_o    = req_q.is_store;
                dmem.dmem_addr_o = {req_q.addr[ADDR_WIDTH-1:2], 2'b00};
                // Loads present no write lanes.
                if (req_q.is_store) begin
                    dmem.dmem_wdata_o = lane_wdata;
                    dmem.dmem_mask_o  = lane_mask;
                end
            end

            ST_DONE: begin
                // x0 is hard-wired zero, so a load into it never writes back.
                wb_v_o    = (req_q.rd != '0);
                wb_addr_o = req_q.rd;
                wb_data_o = load_data_q;
            end

            ST_ERROR: begin
                err_o      = 1'b1;
                err_code_o = err_code_q;
            end

            default: begin
            end
        endcase
    end

endmodule

// File: doc/cl_mem_sequencer.md
Name: cl_mem_sequencer

Overview:
- Sequences one decoded load/store at a time from the core pipeline to the data-memory port.
- Drives the dmem valid/yumi request handshake and waits for the load response.
- Performs byte-lane steering for LBU/SB, stalls the pipeline while busy, and returns load results to the register-file write port.
- Sits between the decode/execute stage and the dmem interface.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32 for lane logic (4 byte lanes).
- RF_ADDR_WIDTH, 5, register-file index width.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT_RSP before an error abort.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- req_valid_i  in  1  mem op presented by pipeline
- req_ready_o  out  1  sequencer can accept a request
- is_store_i  in  1  1 = store, 0 = load
- is_byte_i  in  1  byte op (LBU/SB)
- addr_i  in  ADDR_WIDTH  effective byte address
- store_data_i  in  32  store source register value
- rd_addr_i  in  RF_ADDR_WIDTH  load destination register
- dmem_v_o  out  1  dmem request valid
- dmem_w_o  out  1  dmem write enable
- dmem_addr_o  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata_o  out  32  lane-replicated write data
- dmem_mask_o  out  4  byte write mask
- dmem_yumi_i  in  1  dmem accepted request this cycle
- dmem_rsp_v_i  in  1  load response valid
- dmem_rdata_i  in  32  load response word
- wb_v_o  out  1  register-file write pulse
- wb_addr_o  out  RF_ADDR_WIDTH  write index
- wb_data_o  out  32  write data
- stall_o  out  1  pipeline stall
- err_o  out  1  one-cycle error pulse
- err_code_o  out  2  0 none, 1 misaligned, 2 timeout

Behaviour:
- Reset (async, any state):
  - State goes to IDLE and the timeout counter clears.
  - All outputs are 0, except req_ready_o = 1.
  - An in-flight request is abandoned; a late dmem_rsp_v_i arriving after reset is ignored.
- States: IDLE, REQ, WAIT_RSP, DONE, ERROR.
- IDLE:
  - req_ready_o = 1, stall_o = 0.
  - On req_valid_i, capture all request fields.
  - A word op with addr_i[1:0] != 0 goes to ERROR; every other request goes to REQ.
- REQ:
  - dmem_v_o = 1; address, data and mask held stable until dmem_yumi_i.
  - Store with yumi goes to IDLE; load with yumi goes to WAIT_RSP.
  - No timeout in REQ.
- WAIT_RSP:
  - Counter increments each cycle.
  - dmem_rsp_v_i: register the load data, go to DONE.
  - Counter reaching TIMEOUT_CYCLES-1 without a response: go to ERROR with code 2.
  - A response arriving in the same cycle as the timeout wins.
- DONE:
  - wb_v_o = 1 for one cycle with captured rd and load data, then go to IDLE.
  - wb_v_o is suppressed when rd = 0.
- ERROR: err_o = 1 and err_code_o valid for one cycle, no dmem access, no writeback, then go to IDLE.
- stall_o = (state != IDLE); req_ready_o = (state == IDLE).
- Lane rules, with lane = addr[1:0]:
  - Word store: mask 4'hF, wdata = store_data.
  - Byte store: mask = 4'b0001 << lane, wdata = {4{store_data[7:0]}}.
  - Word load: data = rdata.
  - Byte load: data = {24'b0, rdata[8*lane +: 8]} (zero-extend).
- dmem_w_o = captured is_store during REQ, 0 otherwise.
- Latency, load with immediate yumi and response next cycle:
  - accept at T0, dmem_v_o at T1, response at T2, wb_v_o at T3.
  - Store completes at T1 yumi; ready again at T2.
- Spurious dmem_rsp_v_i outside WAIT_RSP is ignored.

Decomposition:
- Shared definitions package:
  - state enum mem_seq_state_e.
  - err code constants kErrNone/kErrMisalign/kErrTimeout.
  - mem request struct mem_req_s {is_store, is_byte, addr, data, rd}.
- One sub-module, cl_mem_lane_align (combinational): mask and wdata generation, and byte extraction/zero-extend.
- FSM, capture registers and counter live in the top module.

Test Plan:
- LW addr 0x0000_0010, rd=3, yumi immediate, rdata 0xDEADBEEF one cycle later:
  - wb_v_o at T3, wb_addr=3, wb_data=0xDEADBEEF.
  - stall_o high T1–T3.
- SB addr 0x0000_0007, data 0x0000_00A5, yumi delayed 3 cycles:
  - dmem_v_o held 4 cycles, mask 4'b1000, wdata 0xA5A5A5A5, w=1.
  - No wb_v_o.
- LBU addr 0x0000_0002, rdata 0x11223344:
  - wb_data 0x00000022.
  - Repeat at lane 3 for 0x00000011.
- LW addr 0x0000_0006:
  - No dmem_v_o; err_o pulse with code 1 at T1; req_ready_o back high at T2.
- LW with no response:
  - err_o code 2 after TIMEOUT_CYCLES in WAIT_RSP; no wb_v_o.
  - Then issue LW rd=0 with response: no wb_v_o.
- Assert reset in WAIT_RSP, release, then drive dmem_rsp_v_i:
  - Outputs at reset values, state IDLE, no wb_v_o.
  - A following SW completes normally.
